// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL lock supervisor / reset sequencer.
// Holds the sequencer state encoding, default timing constants and counter sizing helpers.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    PLL_RESET = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYC = 500000;
  localparam int DEF_PLL_RST_CYC      = 64;
  localparam int DEF_STAGE_DLY_CYC    = 16;
  localparam int DEF_CNT_W            = 8;

  // Width of a counter that must reach max_val-1; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync_2ff.sv
// Two-flop synchronizer for asynchronous status bits, one independent chain per bit.
// Clears to zero on the asynchronous reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_q[gi] <= 1'b0;
        sync_q[gi] <= 1'b0;
      end else begin
        meta_q[gi] <= d_i[gi];
        sync_q[gi] <= meta_q[gi];
      end
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL lock supervisor: qualifies lock, releases staged resets, retries the PLL on
// lock timeout and keeps saturating loss/retry counters for status registers.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
  parameter int STAGE_DLY_CYC    = DEF_STAGE_DLY_CYC,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             cl_rst,
  output logic             lock_ok,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam int MAX_CYC = max4(LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC, PLL_RST_CYC, STAGE_DLY_CYC);
  localparam int CW      = cnt_width(MAX_CYC);

  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] PRC_LAST = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] STG_LAST = CW'(STAGE_DLY_CYC - 1);

  logic             lock_s;
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             pll_rst_q;
  logic             sys_rst_q;
  logic             cl_rst_q;
  logic             lock_ok_q;
  logic [CNT_W-1:0] loss_q;
  logic [CNT_W-1:0] retry_q;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_lock),
    .q_o (lock_s)
  );

  // One shared counter serves timeout, stable, pulse and stage timing; it clears
  // on every state transition so each state sees it start from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      pll_rst_q <= 1'b0;
      sys_rst_q <= 1'b1;
      cl_rst_q  <= 1'b1;
      lock_ok_q <= 1'b0;
      loss_q    <= '0;
      retry_q   <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TMO_LAST) begin
            state_q   <= PLL_RESET;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            if (retry_q != '1) retry_q <= retry_q + CNT_W'(1);
          end
        end
        STABLE: begin
          // A drop here is just an unqualified lock, not a loss; it wins over completion.
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STB_LAST) begin
            state_q   <= RELEASE;
            cnt_q     <= '0;
            sys_rst_q <= 1'b0;
            lock_ok_q <= 1'b1;
          end
        end
        PLL_RESET: begin
          if (cnt_q == PRC_LAST) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end
        end
        RELEASE, RUN: begin
          if (!lock_s) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            sys_rst_q <= 1'b1;
            cl_rst_q  <= 1'b1;
            lock_ok_q <= 1'b0;
            if (loss_q != '1) loss_q <= loss_q + CNT_W'(1);
          end else if (state_q == RELEASE && cnt_q == STG_LAST) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            cl_rst_q <= 1'b0;
          end else if (state_q == RUN) begin
            cnt_q <= cnt_q;
          end
        end
        default: begin
          state_q   <= WAIT_LOCK;
          cnt_q     <= '0;
          pll_rst_q <= 1'b0;
          sys_rst_q <= 1'b1;
          cl_rst_q  <= 1'b1;
          lock_ok_q <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign cl_rst    = cl_rst_q;
  assign lock_ok   = lock_ok_q;
  assign loss_cnt  = loss_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Randomized bench for pll_rst_seq against a timestamp-based reference model,
// checking every output on every cycle plus asynchronous reset behaviour.
module tb_pll_rst_seq;

  localparam int STB  = 8;
  localparam int TMO  = 32;
  localparam int PRC  = 4;
  localparam int STG  = 3;
  localparam int CW   = 2;
  localparam int SATV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          pll_lock;
  logic          pll_rst;
  logic          sys_rst;
  logic          cl_rst;
  logic          lock_ok;
  logic [CW-1:0] loss_cnt;
  logic [CW-1:0] retry_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: the block is "waiting", "pulsing" or "released"; all timing is
  // expressed as distances between edge numbers rather than as counters.
  int n, since, run, pulse_start, rel_edge, mode;
  bit s1, s2;
  bit m_sys, m_cl, m_pll, m_ok;
  int m_loss, m_retry;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .LOCK_STABLE_CYC  (STB),
    .LOCK_TIMEOUT_CYC (TMO),
    .PLL_RST_CYC      (PRC),
    .STAGE_DLY_CYC    (STG),
    .CNT_W            (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .cl_rst    (cl_rst),
    .lock_ok   (lock_ok),
    .loss_cnt  (loss_cnt),
    .retry_cnt (retry_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; since = 0; run = 0; pulse_start = 0; rel_edge = 0; mode = 0;
    s1 = 0; s2 = 0;
    m_sys = 1; m_cl = 1; m_pll = 0; m_ok = 0; m_loss = 0; m_retry = 0;
  endtask

  task automatic model_step();
    bit ls;
    n++;
    ls = s2;
    s2 = s1;
    s1 = pll_lock;
    case (mode)
      0: begin
        if (ls) begin
          run++;
          if (run == STB + 1) begin
            mode = 2; rel_edge = n; m_sys = 0; m_ok = 1;
          end
        end else if (run > 0) begin
          run = 0; since = n;
        end else if (n - since == TMO) begin
          mode = 1; pulse_start = n; m_pll = 1;
          if (m_retry < SATV) m_retry++;
        end
      end
      1: begin
        if (n - pulse_start == PRC) begin
          mode = 0; since = n; run = 0; m_pll = 0;
        end
      end
      default: begin
        if (!ls) begin
          mode = 0; since = n; run = 0;
          m_sys = 1; m_cl = 1; m_ok = 0;
          if (m_loss < SATV) m_loss++;
        end else if (n - rel_edge == STG) begin
          m_cl = 0;
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    check("sys_rst",   32'(sys_rst),   32'(m_sys));
    check("cl_rst",    32'(cl_rst),    32'(m_cl));
    check("pll_rst",   32'(pll_rst),   32'(m_pll));
    check("lock_ok",   32'(lock_ok),   32'(m_ok));
    check("loss_cnt",  32'(loss_cnt),  m_loss);
    check("retry_cnt", 32'(retry_cnt), m_retry);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      pll_lock = v;
      tick();
    end
  endtask

  // Asserts rst between edges and checks the outputs clear before any clock edge.
  task automatic do_async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int budget;
    int len;
    bit v;

    rst = 1'b1;
    pll_lock = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Clean lock, then loss in RUN and relock.
    drive(0, 5);
    drive(1, 30);
    drive(0, 10);
    drive(1, 30);

    // Glitchy lock: a one-cycle dropout restarts qualification.
    drive(0, 6);
    drive(1, 5);
    drive(0, 1);
    drive(1, 25);

    // Long loss: repeated PLL reset retries saturate retry_cnt.
    drive(0, 170);

    // Async reset in the middle of a pll_rst pulse.
    budget = 0;
    while (mode != 1 && budget < 200) begin
      drive(0, 1);
      budget++;
    end
    check("reach_pulse", 32'(mode == 1), 32'd1);
    drive(0, 1);
    do_async_reset();

    // Lock drops immediately after release so the loss lands inside RELEASE.
    budget = 0;
    while (m_sys && budget < 100) begin
      drive(1, 1);
      budget++;
    end
    check("reach_release", 32'(m_sys), 32'd0);
    drive(0, 8);

    // Random lock activity with occasional asynchronous resets.
    for (int seg = 0; seg < 60; seg++) begin
      v = 1'($urandom_range(0, 1));
      if (v) len = $urandom_range(1, 20);
      else if ($urandom_range(0, 5) == 0) len = $urandom_range(30, 45);
      else len = $urandom_range(1, 6);
      drive(v, len);
      if ($urandom_range(0, 19) == 0) do_async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
